// File: rtl/lcd_instr_arbiter.sv
// rtl/lcd_instr_arbiter.sv - round-robin arbiter sharing one LCD instruction FSM between two requesters
// Optional clear/home hold-off state is built only when LCD_CLEAR_WAIT_EN is defined.
module lcd_instr_arbiter #(
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [9:0] data0,
    input  logic [9:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       fsm_enable,
    output logic [9:0] fsm_data,
    input  logic       fsm_done,
    output logic       busy
);

`ifdef LCD_CLEAR_WAIT_EN
    typedef enum logic [1:0] {IDLE, EXEC, RELEASE, CLRWAIT} state_t;

    localparam int CW = (CLEAR_WAIT_CYCLES > 1) ? $clog2(CLEAR_WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLEAR_WAIT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
    logic          is_clear;

    // Clear display (0x001) and return home (0x002/0x003) need the long LCD settle time.
    assign is_clear = (fsm_data != 10'h000) && (fsm_data <= 10'h003);
`else
    typedef enum logic [1:0] {IDLE, EXEC, RELEASE} state_t;

    logic unused_clear_wait;
    assign unused_clear_wait = (CLEAR_WAIT_CYCLES != 0);
`endif

    state_t state;
    logic   last;
    logic   winner;

    // last doubles as the index of the requester currently being served.
    assign winner = (req0 && req1) ? ~last : req1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fsm_enable <= 1'b0;
            fsm_data   <= 10'h000;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            last       <= 1'b1;
`ifdef LCD_CLEAR_WAIT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        fsm_data   <= winner ? data1 : data0;
                        fsm_enable <= 1'b1;
                        last       <= winner;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (fsm_done) begin
                        fsm_enable <= 1'b0;
                        ack0       <= ~last;
                        ack1       <= last;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!fsm_done) begin
`ifdef LCD_CLEAR_WAIT_EN
                        if (is_clear) begin
                            wait_cnt <= '0;
                            state    <= CLRWAIT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                end
`ifdef LCD_CLEAR_WAIT_EN
                CLRWAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    fsm_enable <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_instr_arbiter.sv
// tb/tb_lcd_instr_arbiter.sv - self-checking bench for lcd_instr_arbiter with a transaction-level reference model
module tb_lcd_instr_arbiter;
    localparam int CWC = 100;
`ifdef LCD_CLEAR_WAIT_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, req0, req1, fsm_done;
    logic [9:0] data0, data1;
    logic       ack0, ack1, fsm_enable, busy;
    logic [9:0] fsm_data;

    lcd_instr_arbiter #(.CLEAR_WAIT_CYCLES(CWC)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1),
        .fsm_enable(fsm_enable), .fsm_data(fsm_data), .fsm_done(fsm_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one transaction in flight, a release wait, then an optional hold-off countdown.
    bit         m_inflight, m_waitlow, m_last, m_who;
    int         m_hold;
    logic [9:0] m_word;
    bit         e_a0, e_a1;

    // Scoreboard and instruction-FSM responder state
    bit         prev_en, rose_now;
    int         rise_cyc, ack_cyc, n_fall, n_ack;
    bit         ack_q[$];
    logic [9:0] grant_q[$];
    bit         auto_resp, rand_resp;
    int         resp_delay, resp_len, wait_left, done_left;

    task automatic model_step(input logic r, input logic q0, input logic q1,
                              input logic [9:0] d0, input logic [9:0] d1, input logic dn);
        e_a0 = 1'b0;
        e_a1 = 1'b0;
        if (r) begin
            m_inflight = 0; m_waitlow = 0; m_hold = 0; m_last = 1; m_word = 10'h000;
        end else if (m_inflight) begin
            if (dn) begin
                m_inflight = 0;
                m_waitlow  = 1;
                if (m_who) e_a1 = 1'b1; else e_a0 = 1'b1;
            end
        end else if (m_waitlow) begin
            if (!dn) begin
                m_waitlow = 0;
                if (CLR_EN && m_word >= 10'd1 && m_word <= 10'd3) m_hold = CWC;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (q0 || q1) begin
            m_who      = (q0 && q1) ? !m_last : q1;
            m_last     = m_who;
            m_word     = m_who ? d1 : d0;
            m_inflight = 1;
        end
    endtask

    task automatic tick();
        logic r, q0, q1, dn;
        logic [9:0] d0, d1;
        logic [13:0] act, expv;
        bit e_busy;
        r = reset; q0 = req0; q1 = req1; dn = fsm_done; d0 = data0; d1 = data1;
        @(posedge clk);
        model_step(r, q0, q1, d0, d1, dn);
        #1;
        cyc++;
        e_busy = m_inflight || m_waitlow || (m_hold > 0);
        act  = {fsm_enable, fsm_data, ack0, ack1, busy};
        expv = {m_inflight, m_word, e_a0, e_a1, e_busy};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL cycle_model @%0d {en,data,ack0,ack1,busy} got %h expected %h", cyc, act, expv);
        end
        rose_now = fsm_enable && !prev_en;
        if (rose_now) begin
            rise_cyc = cyc;
            grant_q.push_back(fsm_data);
        end
        if (!fsm_enable && prev_en) n_fall++;
        if (ack0) begin ack_q.push_back(1'b0); ack_cyc = cyc; n_ack++; end
        if (ack1) begin ack_q.push_back(1'b1); ack_cyc = cyc; n_ack++; end
        if (auto_resp) begin
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0) fsm_done = 1'b0;
            end else begin
                if (rose_now) wait_left = rand_resp ? int'($urandom_range(0, 6)) : resp_delay;
                if (fsm_enable) begin
                    if (wait_left == 0) begin
                        fsm_done  = 1'b1;
                        done_left = rand_resp ? int'($urandom_range(1, 4)) : resp_len;
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
        prev_en = fsm_enable;
    endtask

    task automatic wait_ack(input bit who, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if ((who ? ack1 : ack0) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_rise(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if (rose_now) ok = 1'b1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_log();
        ack_q.delete();
        grant_q.delete();
        n_fall = 0;
        n_ack  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b0; data0 = 10'h155; data1 = 10'h0AA; fsm_done = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({fsm_enable, fsm_data} !== 11'h000) begin
            errors++;
            $display("FAIL reset_enable_data got %h expected %h", {fsm_enable, fsm_data}, 11'h000);
        end
        checks++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ack_busy got %b expected 000", {ack0, ack1, busy});
        end
        req0 = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        clear_log();
        auto_resp = 1; rand_resp = 0; resp_delay = 39; resp_len = 1;
        req0 = 1'b1; data0 = 10'h028;
        wait_ack(1'b0, 200, ok);
        req0 = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_ack_timeout got none expected ack0"); end
        checks++;
        if (grant_q.size() != 1 || grant_q[0] !== 10'h028) begin
            errors++;
            $display("FAIL single_data got %h (grants %0d) expected 028", fsm_data, grant_q.size());
        end
        checks++;
        if (ack_cyc - rise_cyc != 40) begin
            errors++;
            $display("FAIL single_ack_latency got %0d expected 40", ack_cyc - rise_cyc);
        end
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || n_ack != 1 || ack_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_release busy=%b acks=%0d expected busy=0 acks=1", busy, n_ack);
        end
    endtask

    task automatic test_contention();
        bit ok;
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 10'h241; data1 = 10'h242;
        tick(); tick();
        clear_log();
        reset = 1'b0;
        auto_resp = 1; rand_resp = 0; resp_delay = 2; resp_len = 1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (n_ack >= 4) ok = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (!ok || ack_q.size() < 4) begin
            errors++;
            $display("FAIL contention_timeout got %0d acks expected 4", ack_q.size());
        end else begin
            checks++;
            if ({ack_q[0], ack_q[1], ack_q[2], ack_q[3]} !== 4'b0101) begin
                errors++;
                $display("FAIL contention_order got %b expected 0101", {ack_q[0], ack_q[1], ack_q[2], ack_q[3]});
            end
            checks++;
            if ({grant_q[0], grant_q[1], grant_q[2], grant_q[3]} !== {10'h241, 10'h242, 10'h241, 10'h242}) begin
                errors++;
                $display("FAIL contention_data got %h %h %h %h expected 241 242 241 242",
                         grant_q[0], grant_q[1], grant_q[2], grant_q[3]);
            end
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_level_done();
        bit ok;
        int a;
        clear_log();
        auto_resp = 1; rand_resp = 0; resp_delay = 3; resp_len = 5;
        req0 = 1'b1; data0 = 10'h0C5; req1 = 1'b1; data1 = 10'h180;
        wait_ack(1'b0, 100, ok);
        req0 = 1'b0;
        a = ack_cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL level_ack0_timeout got none expected ack0"); end
        wait_rise(100, ok);
        checks++;
        if (!ok || rise_cyc - a != 6) begin
            errors++;
            $display("FAIL level_regrant_gap got %0d expected 6", rise_cyc - a);
        end
        checks++;
        if (n_fall != 1 || fsm_data !== 10'h180) begin
            errors++;
            $display("FAIL level_fall_data got falls=%0d data=%h expected falls=1 data=180", n_fall, fsm_data);
        end
        wait_ack(1'b1, 100, ok);
        req1 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_clear();
        bit ok;
        int a, exp_gap;
        apply_reset();
        clear_log();
        auto_resp = 1; rand_resp = 0; resp_delay = 3; resp_len = 1;
        req0 = 1'b1; data0 = 10'h001; req1 = 1'b1; data1 = 10'h10F;
        wait_ack(1'b0, 100, ok);
        req0 = 1'b0;
        a = ack_cyc;
        exp_gap = CLR_EN ? CWC + 2 : 2;
        wait_rise(400, ok);
        checks++;
        if (!ok || rise_cyc - a != exp_gap) begin
            errors++;
            $display("FAIL clear_gap got %0d expected %0d", rise_cyc - a, exp_gap);
        end
        checks++;
        if (fsm_data !== 10'h10F) begin
            errors++;
            $display("FAIL clear_req1_data got %h expected 10f", fsm_data);
        end
        wait_ack(1'b1, 100, ok);
        req1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        int acks_before;
        auto_resp = 0; done_left = 0; fsm_done = 1'b0;
        req0 = 1'b1; data0 = 10'h0A7;
        wait_rise(20, ok);
        for (int i = 0; i < 5; i++) tick();
        acks_before = n_ack;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({fsm_enable, busy, ack0, ack1} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs got %b expected 0000", {fsm_enable, busy, ack0, ack1});
        end
        tick();
        checks++;
        if (fsm_enable !== 1'b1 || fsm_data !== 10'h0A7) begin
            errors++;
            $display("FAIL midreset_regrant got en=%b data=%h expected en=1 data=0a7", fsm_enable, fsm_data);
        end
        checks++;
        if (n_ack != acks_before) begin
            errors++;
            $display("FAIL midreset_no_ack got %0d acks expected %0d", n_ack, acks_before);
        end
        fsm_done = 1'b1;
        wait_ack(1'b0, 10, ok);
        fsm_done = 1'b0;
        req0 = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_ack_timeout got none expected ack0"); end
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_random();
        bit ok;
        auto_resp = 1; rand_resp = 1; done_left = 0; fsm_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            tick();
            if (ack0 && $urandom_range(0, 1) == 0) req0 = 1'b0;
            if (ack1 && $urandom_range(0, 1) == 0) req1 = 1'b0;
            if (req0 && m_inflight && !m_who && $urandom_range(0, 7) == 0) req0 = 1'b0;
            if (req1 && m_inflight && m_who && $urandom_range(0, 7) == 0) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1;
                data0 = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(1, 3)) : 10'($urandom);
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1;
                data1 = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(1, 3)) : 10'($urandom);
            end
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (!busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL random_drain got busy=%b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; fsm_done = 1'b0;
        auto_resp = 0; rand_resp = 0; resp_delay = 0; resp_len = 1; wait_left = 0; done_left = 0;
        m_inflight = 0; m_waitlow = 0; m_hold = 0; m_last = 1; m_who = 0; m_word = '0;
        prev_en = 0; rise_cyc = 0; ack_cyc = 0;
        clear_log();
        test_reset();
        test_single();
        test_contention();
        test_level_done();
        test_clear();
        test_reset_mid_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion expected finish");
        $fatal(1);
    end
endmodule

// File: doc/lcd_instr_arbiter.md
LCD_INSTR_ARBITER -- requirements
Module: lcd_instr_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_WAIT_CYCLES, default 82000, meaning post-clear/home hold-off in clk cycles (1.64 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  requester 0/1 instruction request, level, held until matching ack.
REQ-005 SHALL have ports data0/data1  input  10  requester word {RS,RW,D7..D0}, stable while req high.
REQ-006 SHALL have ports ack0/ack1  output  1  one-cycle pulse, granted word fully executed.
REQ-007 SHALL have port fsm_enable  output  1  drives instruction FSM ENABLE.
REQ-008 SHALL have port fsm_data  output  10  drives instruction FSM data.
REQ-009 SHALL have port fsm_done  input  1  instruction FSM FSM_done, level or pulse.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, EXEC, RELEASE, CLRWAIT.
REQ-012 IDLE, any req high at edge t: SHALL latch winner's data into fsm_data, set fsm_enable=1, enter EXEC, all registered at edge t.
REQ-013 Arbitration SHALL be round-robin: both req high -> grant requester not granted last; single req -> that requester.
REQ-014 Last-grant pointer SHALL reset to 1, so requester 0 wins the first simultaneous request.
REQ-015 EXEC: fsm_enable and fsm_data SHALL stay constant until fsm_done sampled high.
REQ-016 EXEC, fsm_done high: SHALL clear fsm_enable, pulse ack of granted requester for exactly one cycle, enter RELEASE.
REQ-017 RELEASE: SHALL wait for fsm_done low, then enter IDLE, or CLRWAIT per REQ-026.
REQ-018 Arbiter SHALL not sample req0/req1 outside IDLE; a new grant needs at least one IDLE cycle (min two cycles ack to next fsm_enable).
REQ-019 Req dropped after latch SHALL not abort the transaction; ack still pulses.
REQ-020 Req held high through its own ack cycle SHALL be treated as a new request in IDLE.
REQ-021 fsm_data SHALL hold the last issued word while idle.
REQ-022 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-023 reset high at any edge, any state: SHALL enter IDLE and clear the CLRWAIT counter; an in-flight transaction is dropped with no ack.
REQ-024 Reset values SHALL be: fsm_enable=0, fsm_data=10'h000, ack0=0, ack1=0, busy=0, last-grant=1.

Configuration
REQ-025 Macro LCD_CLEAR_WAIT_EN SHALL control the clear/home hold-off.
REQ-026 With LCD_CLEAR_WAIT_EN defined: word 10'h001, 10'h002 or 10'h003 leaves RELEASE to CLRWAIT; count exactly CLEAR_WAIT_CYCLES cycles, busy=1, no grants; then IDLE.
REQ-027 Without LCD_CLEAR_WAIT_EN: CLRWAIT and its counter SHALL not be synthesised; RELEASE always goes to IDLE.

Verification
REQ-028 Bench SHALL cover single request: req0=1, data0=10'h028, fsm_done pulses high 40 cycles after fsm_enable rises -> fsm_data=10'h028; one ack0 pulse the cycle after done; busy low after release.
REQ-029 Bench SHALL cover contention: req0 and req1 both high from reset release (data0=10'h241, data1=10'h242) -> grants in order 0,1,0,1; acks alternate; no overlap.
REQ-030 Bench SHALL cover level done: fsm_done held high 5 cycles -> fsm_enable falls once; no new grant until done low plus one IDLE cycle.
REQ-031 Bench SHALL cover clear hold-off (macro defined, CLEAR_WAIT_CYCLES=100): data0=10'h001, req1 pending -> fsm_enable for req1 rises no earlier than 100 cycles after done falls.
REQ-032 Bench SHALL cover macro undefined, same stimulus as REQ-031 -> req1 granted two cycles after ack0.
REQ-033 Bench SHALL cover reset mid-EXEC: reset one cycle -> next cycle fsm_enable=0, busy=0, no ack; pending req0 granted after reset release.
